d3s_lut_bank_ctrl: RTL
======================

Name: d3s_lut_bank_ctrl

Overview:
Controller for the double-buffered sine/slope LUT feeding the D3S DAC sample path. It accepts host writes of LUT words into the inactive (shadow) bank, can bulk-clear the shadow bank, and swaps active/shadow banks only on a frame-sync strobe, so the phase-to-sample lookup never sees a partially written table. It drives the LUT memory write port and the bank select used by the read side.

Parameters:
g_lut_size_log2, 10, log2 of LUT entries per bank
g_lut_sample_bits, 18, sample field width (LSBs of LUT word)
g_lut_slope_bits, 18, slope field width (MSBs of LUT word)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
host_addr_i  in  g_lut_size_log2  write-pointer load value
host_addr_load_i  in  1  load write pointer from host_addr_i
host_data_i  in  g_lut_sample_bits+g_lut_slope_bits  LUT word {slope,sample}
host_wr_i  in  1  write request
host_ready_o  out  1  write/load accepted this cycle when high
host_clear_i  in  1  start clear of shadow bank
host_commit_i  in  1  request bank swap
swap_sync_i  in  1  frame-boundary strobe; swaps allowed only here
lut_we_o  out  1  LUT write enable
lut_bank_o  out  1  bank being written (always shadow)
lut_addr_o  out  g_lut_size_log2  LUT write address
lut_data_o  out  g_lut_sample_bits+g_lut_slope_bits  LUT write data
active_bank_o  out  1  bank used by the read datapath
busy_o  out  1  state != IDLE
commit_done_o  out  1  one-cycle pulse on completed swap
overrun_o  out  1  sticky: host_wr_i seen while host_ready_o low

Behaviour:
- Reset (async, rst_n_i=0): state IDLE, wptr=0, active_bank_o=0, lut_we_o=0, lut_addr_o=0, lut_data_o=0, lut_bank_o=1, busy_o=0, commit_done_o=0, overrun_o=0. Reset mid-clear or mid-commit aborts the operation with no swap.
- lut_bank_o = ~active_bank_o at all times (registered).
- host_ready_o = (state==IDLE) & ~host_clear_i & ~host_commit_i (combinational).
- Priority in IDLE: clear > commit > addr_load > write.
- IDLE, accepted write (host_wr_i & host_ready_o): next cycle lut_we_o=1, lut_addr_o=effective address, lut_data_o=host_data_i; wptr=effective address+1, wraps 2^N-1 -> 0. Latency 1 cycle.
- addr_load and wr in the same cycle: effective address = host_addr_i. The write lands at host_addr_i and wptr becomes host_addr_i+1. addr_load alone: wptr=host_addr_i, no write.
- CLEAR: entered on host_clear_i in IDLE. Writes zero to shadow addresses 0..2^N-1, one per cycle (lut_we_o high for exactly 2^N consecutive cycles, starting the cycle after entry). Then wptr=0 and state returns to IDLE.
- COMMIT_WAIT: entered on host_commit_i in IDLE. On the first swap_sync_i in a later cycle (a sync coincident with the commit cycle does not count):
  - active_bank_o toggles at that edge;
  - commit_done_o pulses 1 cycle;
  - wptr=0 and overrun_o clears;
  - state returns to IDLE.
  No LUT writes occur during COMMIT_WAIT. No timeout.
- overrun_o sets when host_wr_i=1 and host_ready_o=0. It is sticky until commit completion or reset. Dropped writes do not modify wptr.
- busy_o is high in CLEAR and COMMIT_WAIT.
- lut_we_o is 0 in every cycle not listed above.

Test Plan:
- Reset, then 3 writes (0xA, 0xB, 0xC) with no addr_load -> lut_we_o pulses with addr 0, 1, 2, lut_bank_o=1, data as written, each 1 cycle after acceptance.
- addr_load to 1023 plus write 0x5, then write 0x6 -> writes land at addr 1023 then 0 (wrap).
- host_clear_i for 1 cycle with g_lut_size_log2=10 -> exactly 1024 consecutive lut_we_o cycles, data 0, addr 0..1023; busy_o high throughout; host_ready_o low; a host_wr_i mid-clear sets overrun_o and produces no write.
- host_commit_i with swap_sync_i in the same cycle, then sync 5 cycles later -> no swap on the first sync; on the later sync active_bank_o 0->1, lut_bank_o 1->0, commit_done_o single pulse, overrun_o cleared.
- host_clear_i, host_commit_i and host_wr_i all high in the same cycle -> clear runs, no commit, no host write, overrun_o=1.
- rst_n_i asserted during COMMIT_WAIT (and separately mid-clear) -> immediate return to reset values, active_bank_o=0, no commit_done_o pulse.

Source files
------------

// File: rtl/d3s_lut_bank_ctrl.sv
// Write-side controller for the double-buffered D3S sine/slope LUT.
// Host writes and bulk clears target the shadow bank; banks swap only on a frame-sync strobe.
`timescale 1ns/1ps
module d3s_lut_bank_ctrl #(
  parameter int g_lut_size_log2   = 10,
  parameter int g_lut_sample_bits = 18,
  parameter int g_lut_slope_bits  = 18
) (
  input  logic                                       clk_i,
  input  logic                                       rst_n_i,
  input  logic [g_lut_size_log2-1:0]                 host_addr_i,
  input  logic                                       host_addr_load_i,
  input  logic [g_lut_sample_bits+g_lut_slope_bits-1:0] host_data_i,
  input  logic                                       host_wr_i,
  output logic                                       host_ready_o,
  input  logic                                       host_clear_i,
  input  logic                                       host_commit_i,
  input  logic                                       swap_sync_i,
  output logic                                       lut_we_o,
  output logic                                       lut_bank_o,
  output logic [g_lut_size_log2-1:0]                 lut_addr_o,
  output logic [g_lut_sample_bits+g_lut_slope_bits-1:0] lut_data_o,
  output logic                                       active_bank_o,
  output logic                                       busy_o,
  output logic                                       commit_done_o,
  output logic                                       overrun_o
);

  localparam int LW = g_lut_sample_bits + g_lut_slope_bits;
  localparam logic [g_lut_size_log2-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_COMMIT_WAIT
  } state_t;

  state_t                     state_q, state_d;
  logic [g_lut_size_log2-1:0] wptr_q, wptr_d;
  logic                       active_q, active_d;
  logic                       bank_q, bank_d;
  logic                       we_q, we_d;
  logic [g_lut_size_log2-1:0] addr_q, addr_d;
  logic [LW-1:0]              data_q, data_d;
  logic                       done_q, done_d;
  logic                       overrun_q, overrun_d;
  logic [g_lut_size_log2-1:0] eff_addr;
  logic                       host_ready;

  assign host_ready = (state_q == ST_IDLE) & ~host_clear_i & ~host_commit_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      wptr_q    <= '0;
      active_q  <= 1'b0;
      bank_q    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      active_q  <= active_d;
      bank_q    <= bank_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    active_d  = active_q;
    bank_d    = bank_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    done_d    = 1'b0;
    overrun_d = overrun_q | (host_wr_i & ~host_ready);
    eff_addr  = host_addr_load_i ? host_addr_i : wptr_q;

    case (state_q)
      ST_IDLE: begin
        if (host_clear_i) begin
          // First zero write is issued on the entry edge so the sweep starts next cycle.
          state_d = ST_CLEAR;
          we_d    = 1'b1;
          addr_d  = '0;
          data_d  = '0;
        end else if (host_commit_i) begin
          state_d = ST_COMMIT_WAIT;
        end else if (host_wr_i) begin
          we_d   = 1'b1;
          addr_d = eff_addr;
          data_d = host_data_i;
          wptr_d = eff_addr + 1'b1;
        end else if (host_addr_load_i) begin
          wptr_d = host_addr_i;
        end
      end

      ST_CLEAR: begin
        // The registered LUT address doubles as the sweep counter.
        if (addr_q == ADDR_MAX) begin
          state_d = ST_IDLE;
          wptr_d  = '0;
        end else begin
          we_d   = 1'b1;
          addr_d = addr_q + 1'b1;
          data_d = '0;
        end
      end

      ST_COMMIT_WAIT: begin
        if (swap_sync_i) begin
          state_d   = ST_IDLE;
          active_d  = ~active_q;
          bank_d    = active_q;
          done_d    = 1'b1;
          wptr_d    = '0;
          overrun_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign host_ready_o  = host_ready;
  assign lut_we_o      = we_q;
  assign lut_bank_o    = bank_q;
  assign lut_addr_o    = addr_q;
  assign lut_data_o    = data_q;
  assign active_bank_o = active_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign commit_done_o = done_q;
  assign overrun_o     = overrun_q;

endmodule
